// File: rtl/limp_pkg.sv
// limp_pkg: LIMP bus request/response types plus the arbiter state encoding and helpers.
package limp_pkg;
  localparam int LIMP_ARB_MAX_REQ = 8;
  typedef enum logic [1:0] {LIMP_NOP, LIMP_READ, LIMP_WRITE, LIMP_AMO_READ} limp_cmd_e;
  typedef enum logic [1:0] {LIMP_NOT_READY, LIMP_READY_READ, LIMP_READY_WRITE, LIMP_READY_ILLEGAL} limp_status_e;
  typedef struct packed {
    limp_cmd_e   cmd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_s;
  typedef struct packed {
    limp_status_e status;
    logic [31:0]  rdata;
  } rsp_s;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_LOCKED} arb_state_e;
  function automatic logic req_is_amo(input req_s r);
    return r.cmd == LIMP_AMO_READ;
  endfunction
endpackage

// File: rtl/limp_rr_picker.sv
// limp_rr_picker: combinational round-robin pick of the first set bit at or after i_ptr.
module limp_rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req_vec,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  logic [IW-1:0] w_j;
  // Scan farthest-first so the candidate closest to i_ptr overwrites the rest.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_j      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_req_vec[w_j]) begin
        o_onehot      = '0;
        o_onehot[w_j] = 1'b1;
        o_idx         = w_j;
        o_valid       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/limp_arbiter.sv
// limp_arbiter: round-robin LIMP arbiter with transfer hold and AMO read-to-write locking.
// Define LIMP_ARBITER_LOCK_TIMEOUT_EN to force-release a lock idle for TIMEOUT_CYCLES.
module limp_arbiter
  import limp_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  req_s [NUM_REQ-1:0]   i_req,
  output rsp_s [NUM_REQ-1:0]   o_rsp,
  output req_s                 o_req,
  input  rsp_s                 i_rsp,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_locked,
  output logic                 o_lock_timeout
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > LIMP_ARB_MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("limp_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (x == IW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  arb_state_e          r_state, w_state_nx;
  logic [IW-1:0]       r_owner, r_rr_ptr;
  logic [NUM_REQ-1:0]  w_act, w_win_oh;
  logic [IW-1:0]       w_win_idx, w_sel;
  logic                w_win_valid, w_fwd_valid, w_done, w_lock_go, w_release, w_timeout;
  req_s                w_fwd;

  always_comb begin
    w_act = '0;
    for (int i = 0; i < NUM_REQ; i++) w_act[i] = i_req[i].cmd != LIMP_NOP;
  end

  limp_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .i_req_vec (w_act),
    .i_ptr     (r_rr_ptr),
    .o_onehot  (w_win_oh),
    .o_idx     (w_win_idx),
    .o_valid   (w_win_valid)
  );

  assign w_sel       = (r_state == ARB_IDLE) ? w_win_idx : r_owner;
  assign w_fwd_valid = !i_rst && (r_state != ARB_IDLE || w_win_valid);
  assign w_fwd       = (w_fwd_valid && i_req[w_sel].cmd != LIMP_NOP) ? i_req[w_sel] : '0;
  assign w_done      = w_fwd.cmd != LIMP_NOP && i_rsp.status != LIMP_NOT_READY;
  assign w_lock_go   = w_done && req_is_amo(w_fwd) && i_rsp.status == LIMP_READY_READ;
  // Inside a lock only the owner's write ends it; reads and AMO reads keep it held.
  assign w_release   = w_timeout || (w_done && ((r_state == ARB_LOCKED) ? w_fwd.cmd == LIMP_WRITE : !w_lock_go));

  assign o_req    = w_fwd;
  assign o_grant  = !w_fwd_valid ? '0 : (r_state == ARB_IDLE) ? w_win_oh : NUM_REQ'(1) << r_owner;
  assign o_locked = r_state == ARB_LOCKED;

  always_comb begin
    o_rsp = '0;
    for (int i = 0; i < NUM_REQ; i++) o_rsp[i] = o_grant[i] ? i_rsp : '0;
  end

  always_comb begin
    w_state_nx = w_release ? ARB_IDLE
               : w_lock_go ? ARB_LOCKED
               : (r_state == ARB_IDLE && w_win_valid) ? ARB_BUSY
               : r_state;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ARB_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_owner  <= w_sel;
      r_rr_ptr <= w_release ? inc(w_sel) : r_rr_ptr;
    end
  end

`ifdef LIMP_ARBITER_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] r_cnt;
  logic          r_timeout;
  logic          w_owner_nop;
  assign w_owner_nop    = i_req[r_owner].cmd == LIMP_NOP;
  assign w_timeout      = !i_rst && r_state == ARB_LOCKED && w_owner_nop && r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign o_lock_timeout = r_timeout && !i_rst;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      r_cnt     <= (r_state != ARB_LOCKED || w_done || w_timeout) ? '0 : w_owner_nop ? r_cnt + 1'b1 : r_cnt;
    end
  end
`else
  assign w_timeout      = 1'b0;
  assign o_lock_timeout = 1'b0;
`endif

  // Requesters must hold their request until the transfer completes.
  always_ff @(posedge i_clk) begin
    if (!i_rst && r_state == ARB_BUSY) assert (i_req[r_owner].cmd != LIMP_NOP);
  end
endmodule

// File: tb/tb_limp_arbiter.sv
// tb_limp_arbiter: directed self-checking bench for limp_arbiter with NUM_REQ=2, TIMEOUT_CYCLES=4.
module tb_limp_arbiter;
  import limp_pkg::*;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  req_s [N-1:0]   req;
  rsp_s [N-1:0]   rsp_up;
  req_s           req_dn;
  rsp_s           rsp_dn;
  logic [N-1:0]   grant;
  logic           locked, lto;
  int             n_chk = 0;
  int             n_fail = 0;

  always #5 clk = ~clk;

  limp_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .o_rsp          (rsp_up),
    .o_req          (req_dn),
    .i_rsp          (rsp_dn),
    .o_grant        (grant),
    .o_locked       (locked),
    .o_lock_timeout (lto)
  );

  function automatic req_s mk(input limp_cmd_e c, input logic [31:0] a, input logic [31:0] d);
    req_s r;
    r.cmd = c; r.size = 2'd2; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic rsp_s rs(input limp_status_e s, input logic [31:0] d);
    rsp_s r;
    r.status = s; r.rdata = d;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    req = '0;
    rsp_dn = '0;
    req[0] = mk(LIMP_READ, 32'h100, 32'h0);
    rsp_dn = rs(LIMP_READY_READ, 32'h11);
    #2;
    chk("rst_oreq", req_dn, 128'h0);
    chk("rst_grant", grant, 128'h0);
    chk("rst_rsp0", rsp_up[0], 128'h0);
    chk("rst_locked", locked, 128'h0);
    chk("rst_lto", lto, 128'h0);
    tick;
    rst = 1'b0;
    // single uncontested read, zero added latency
    rsp_dn = rs(LIMP_READY_READ, 32'hAA);
    #1;
    chk("t1_oreq", req_dn, mk(LIMP_READ, 32'h100, 32'h0));
    chk("t1_rsp0", rsp_up[0], rs(LIMP_READY_READ, 32'hAA));
    chk("t1_rsp1", rsp_up[1], rs(LIMP_NOT_READY, 32'h0));
    chk("t1_grant", grant, 128'h1);
    tick;
    // both contend, ready every cycle: rr_ptr is 1 so req1 goes first
    req[0] = mk(LIMP_READ, 32'h200, 32'h0);
    req[1] = mk(LIMP_READ, 32'h300, 32'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant", grant, (k % 2 == 0) ? 128'h2 : 128'h1);
      chk("t2_addr", req_dn.addr, (k % 2 == 0) ? 128'h300 : 128'h200);
      tick;
    end
    // req1 write stalled 3 cycles while req0 waits
    req[1] = mk(LIMP_WRITE, 32'h400, 32'hDEAD);
    rsp_dn = rs(LIMP_NOT_READY, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) rsp_dn = rs(LIMP_READY_WRITE, 32'h0);
      #1;
      chk("t3_grant", grant, 128'h2);
      chk("t3_rsp0", rsp_up[0].status, LIMP_NOT_READY);
      tick;
    end
    req[1] = '0;
    rsp_dn = rs(LIMP_READY_READ, 32'h55);
    #1;
    chk("t3_req0_next", grant, 128'h1);
    chk("t3_rsp0_data", rsp_up[0], rs(LIMP_READY_READ, 32'h55));
    tick;
    // AMO read locks; req1 stalls until req0 writes
    req[0] = mk(LIMP_AMO_READ, 32'h500, 32'h0);
    #1;
    chk("t4_amo_grant", grant, 128'h1);
    chk("t4_pre_lock", locked, 128'h0);
    tick;
    req[0] = '0;
    req[1] = mk(LIMP_READ, 32'h600, 32'h0);
    rsp_dn = rs(LIMP_NOT_READY, 32'h0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t4_locked", locked, 128'h1);
      chk("t4_grant", grant, 128'h1);
      chk("t4_nop_fwd", req_dn, 128'h0);
      chk("t4_rsp1", rsp_up[1].status, LIMP_NOT_READY);
      tick;
    end
    req[0] = mk(LIMP_READ, 32'h504, 32'h0);
    rsp_dn = rs(LIMP_READY_READ, 32'h77);
    #1;
    chk("t4_rd_grant", grant, 128'h1);
    chk("t4_rd_rsp1", rsp_up[1].status, LIMP_NOT_READY);
    tick;
    chk("t4_rd_keeps", locked, 128'h1);
    req[0] = mk(LIMP_WRITE, 32'h500, 32'h1);
    rsp_dn = rs(LIMP_READY_WRITE, 32'h0);
    #1;
    chk("t4_wr_locked", locked, 128'h1);
    chk("t4_wr_cmd", req_dn.cmd, LIMP_WRITE);
    tick;
    req[0] = '0;
    rsp_dn = rs(LIMP_READY_READ, 32'h88);
    #1;
    chk("t4_unlocked", locked, 128'h0);
    chk("t4_req1_grant", grant, 128'h2);
    chk("t4_req1_rsp", rsp_up[1], rs(LIMP_READY_READ, 32'h88));
    tick;
    req[1] = '0;
    // AMO answered illegal: no lock, pointer advances
    req[0] = mk(LIMP_AMO_READ, 32'h700, 32'h0);
    rsp_dn = rs(LIMP_READY_ILLEGAL, 32'h0);
    #1;
    chk("t5_grant", grant, 128'h1);
    tick;
    req[0] = mk(LIMP_READ, 32'h704, 32'h0);
    req[1] = mk(LIMP_READ, 32'h708, 32'h0);
    rsp_dn = rs(LIMP_READY_READ, 32'h0);
    #1;
    chk("t5_no_lock", locked, 128'h0);
    chk("t5_ptr_adv", grant, 128'h2);
    tick;
    // reset mid-BUSY
    req[1] = '0;
    req[0] = mk(LIMP_READ, 32'h800, 32'h0);
    rsp_dn = rs(LIMP_NOT_READY, 32'h0);
    #1;
    chk("t6_grant", grant, 128'h1);
    tick;
    chk("t6_busy_grant", grant, 128'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_oreq", req_dn, 128'h0);
    chk("t6_rst_grant", grant, 128'h0);
    chk("t6_rst_rsp0", rsp_up[0], 128'h0);
    tick;
    rst = 1'b0;
    // reset mid-LOCKED
    req[0] = mk(LIMP_AMO_READ, 32'h900, 32'h0);
    rsp_dn = rs(LIMP_READY_READ, 32'h0);
    #1;
    chk("t6_amo_grant", grant, 128'h1);
    tick;
    req[0] = '0;
    rsp_dn = rs(LIMP_NOT_READY, 32'h0);
    #1;
    chk("t6_locked", locked, 128'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_unlock", locked, 128'h0);
    chk("t6_rst_grant2", grant, 128'h0);
    tick;
    rst = 1'b0;
    #1;
    chk("t6_post_rst", locked, 128'h0);
    tick;
`ifdef LIMP_ARBITER_LOCK_TIMEOUT_EN
    req[0] = mk(LIMP_AMO_READ, 32'hA00, 32'h0);
    rsp_dn = rs(LIMP_READY_READ, 32'h0);
    tick;
    req[0] = '0;
    rsp_dn = rs(LIMP_NOT_READY, 32'h0);
    for (int k = 0; k < 6; k++) begin
      chk("t7_lto", lto, (k == 4) ? 128'h1 : 128'h0);
      chk("t7_locked", locked, (k < 4) ? 128'h1 : 128'h0);
      tick;
    end
`endif
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/limp_arbiter.md
Name: limp_arbiter

Overview:
- Round-robin arbiter that shares one downstream LIMP target port between NUM_REQ LIMP requesters. Typical users are instruction fetch, data access and the debug/DMA path feeding a single memory/bus bridge.
- Adds zero latency on an uncontested request.
- Holds the grant for the full duration of a transfer.
- Locks the port to one requester from an AMO read until that requester's following write, so that read-modify-write sequences are atomic.

Parameters:
- NUM_REQ, 2, number of upstream requesters (2..8).
- TIMEOUT_CYCLES, 64, lock-release timeout in cycles. Used only when LIMP_ARBITER_LOCK_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_req  in  NUM_REQ x $bits(limp_pkg::req_s)  upstream requests, one per requester; requester holds each request stable until its transfer completes
- o_rsp  out  NUM_REQ x $bits(limp_pkg::rsp_s)  upstream responses
- o_req  out  $bits(limp_pkg::req_s)  downstream request
- i_rsp  in  $bits(limp_pkg::rsp_s)  downstream response
- o_grant  out  NUM_REQ  one-hot index of the requester currently forwarded; all zero when none
- o_locked  out  1  high while in LOCKED state
- o_lock_timeout  out  1  one-cycle pulse when a lock is force-released (tied 0 without the macro)

Behaviour:
- Transfer completes at a posedge when the forwarded request is active (cmd != LIMP_NOP) and i_rsp.status != LIMP_NOT_READY.
- States and owner tracking:
  - FSM states: IDLE, BUSY, LOCKED.
  - Registers: owner index, and rr_ptr (the highest-priority index for the next arbitration).
- IDLE:
  - Winner (combinational) = first active requester, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - The winner's i_req is forwarded to o_req in the same cycle, and i_rsp goes to its o_rsp.
  - If there is no winner: o_req.cmd = LIMP_NOP, and addr, wdata and size are 0.
  - If the transfer completes this cycle, apply the completion rules below. Otherwise latch owner = winner and go to BUSY.
- BUSY: forward only the owner, whether or not other requesters are active.
- Completion rules (from IDLE or BUSY):
  - cmd = LIMP_AMO_READ with status LIMP_READY_READ: go to LOCKED with owner kept.
  - Any other case, including LIMP_READY_ILLEGAL on an AMO: go to IDLE with rr_ptr = (owner+1) mod NUM_REQ.
- LOCKED:
  - Forward only the owner. A NOP from the owner forwards NOP, and other requesters remain stalled.
  - Owner completing LIMP_WRITE (any ready status): go to IDLE with rr_ptr = owner+1.
  - Owner completing READ or AMO_READ: stay LOCKED.
- Non-granted requesters: o_rsp.status = LIMP_NOT_READY, rdata = 0.
- Granted requester: o_rsp = i_rsp, passed through unmodified.
- Arbitration is never re-evaluated mid-transfer. A requester dropping its request mid-transfer is a protocol violation; flag it with an assertion only.
- Reset:
  - While i_rst is high: state = IDLE, rr_ptr = 0, owner = 0.
  - Outputs during reset: o_req.cmd = LIMP_NOP with all fields 0, every o_rsp.status = LIMP_NOT_READY with rdata 0, o_grant = 0, o_locked = 0, o_lock_timeout = 0.
  - Reset asserted mid-transfer or mid-lock abandons the transfer or lock immediately.
- rr_ptr wraps from NUM_REQ-1 to 0. Index widths are $clog2(NUM_REQ), minimum 1.

Optional Feature:
- LIMP_ARBITER_LOCK_TIMEOUT_EN defined:
  - In LOCKED, a counter increments each cycle the owner's cmd is LIMP_NOP and is cleared on any owner transfer.
  - When the count reaches TIMEOUT_CYCLES-1 and the owner's cmd is still NOP, the next cycle goes to IDLE with rr_ptr = owner+1, and o_lock_timeout pulses for that one cycle.
- Not defined: no counter, a lock persists indefinitely, o_lock_timeout = 0.

Decomposition:
- Add to limp_pkg:
  - arb_state_e {ARB_IDLE, ARB_BUSY, ARB_LOCKED}
  - a helper function req_is_amo(req_s)
  - the constant LIMP_ARB_MAX_REQ = 8
- One natural sub-module: limp_rr_picker. It is combinational: inputs are a request vector and rr_ptr; outputs are a one-hot winner and its index. It is reusable by other LETC arbiters.

Test Plan:
- Reset, then NUM_REQ=2, only req0 READ addr 0x100, target ready same cycle → o_req = req0 that cycle, o_rsp[0] = READY_READ, o_grant = 2'b01, state IDLE, rr_ptr = 1.
- Req0 and req1 continuously active, target ready every cycle → grants alternate 01, 10, 01, 10; no requester starved.
- Req1 WRITE with target NOT_READY for 3 cycles while req0 asserts → req0 sees NOT_READY throughout; o_grant holds 2'b10 for 4 cycles; req0 granted on the cycle after req1 completes.
- Req0 AMO_READ completes → o_locked = 1. Req1 active for 5 cycles → req1 stalls; req0 READ keeps the lock; req0 WRITE completes → o_locked = 0 next cycle, then req1 granted.
- AMO_READ answered LIMP_READY_ILLEGAL → no lock; o_locked stays 0; rr_ptr advances.
- i_rst asserted mid-BUSY and mid-LOCKED → outputs go to reset values in the same cycle. With LIMP_ARBITER_LOCK_TIMEOUT_EN, TIMEOUT_CYCLES=4, owner idle in LOCKED → o_lock_timeout pulses once after 4 idle cycles, and state returns to IDLE.
